// File: rtl/instruction_sequencer.sv
// instruction_sequencer: issues a preloaded program to the Excutor one opcode at a time,
// handshaking on the executor's Done level and advancing a program counter per completion.
// Optional feature: define SEQ_TIMEOUT_EN to bound each handshake wait by TIMEOUT cycles.

module instruction_sequencer #(
    parameter int unsigned OP_W    = 20,
    parameter int unsigned A_W     = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            Clock,
    input  logic            ResetN,
    input  logic            LoadEn,
    input  logic [A_W-1:0]  LoadAddr,
    input  logic [OP_W-1:0] LoadData,
    input  logic [A_W:0]    Count,
    input  logic            Start,
    input  logic            Done,
    output logic [OP_W-1:0] OpCode,
    output logic [A_W:0]    Pc,
    output logic            Busy,
    output logic            Finished,
    output logic            Error
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitLow,
        StWaitHigh,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [OP_W-1:0] opcode_q, opcode_d;
    logic [A_W:0]    pc_q, pc_d;
    logic [A_W:0]    count_q, count_d;
    logic            busy_q, busy_d;
    logic            finished_q, finished_d;
    logic            wl_seen_q, wl_seen_d;
    logic            complete;
    logic            accept;
    logic            in_wait;
    logic [A_W:0]    pc_inc;

    // Program store; deliberately has no reset so a program survives a run abort.
    logic [OP_W-1:0] store_q [2**A_W];

    assign accept  = (state_q == StIdle) || (state_q == StFinish);
    assign in_wait = (state_q == StWaitLow) || (state_q == StWaitHigh);
    assign pc_inc  = pc_q + {{A_W{1'b0}}, 1'b1};

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            error_q, error_d;
    logic            tmo_hit;

    // This cycle is the TIMEOUT-th one spent in the current wait state.
    assign tmo_hit = in_wait && (tmo_cnt_q == TmoW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Store writes are only honoured while no run is in flight.
    always_ff @(posedge Clock) begin
        if (LoadEn && accept) begin
            store_q[LoadAddr] <= LoadData;
        end
    end

    // Next-state, program counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        opcode_d   = opcode_q;
        wl_seen_d  = 1'b0;
        complete   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        error_d    = error_q;
        tmo_cnt_d  = '0;
`endif

        unique case (state_q)
            StIdle, StFinish: begin
                if (Start) begin
                    count_d = Count;
                    pc_d    = '0;
                    state_d = (Count == '0) ? StFinish : StIssue;
`ifdef SEQ_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            StIssue: begin
                opcode_d = store_q[pc_q[A_W-1:0]];
                state_d  = StWaitLow;
            end
            StWaitLow: begin
                if (!Done) begin
                    state_d = StWaitHigh;
                end else if (wl_seen_q) begin
                    // Done never dropped: the executor finished within one cycle.
                    complete = 1'b1;
                end else begin
                    wl_seen_d = 1'b1;
                end
            end
            StWaitHigh: begin
                if (Done) begin
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (complete) begin
            pc_d    = pc_inc;
            state_d = (pc_inc == count_q) ? StFinish : StIssue;
        end

`ifdef SEQ_TIMEOUT_EN
        if (tmo_hit && !complete) begin
            state_d = StFinish;
            error_d = 1'b1;
        end
        // Counter restarts whenever the state changes and only runs while waiting.
        if (in_wait && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif

        if ((state_d == StIdle) || (state_d == StFinish)) begin
            opcode_d = '0;
        end

        busy_d     = (state_d == StIssue) || (state_d == StWaitLow) || (state_d == StWaitHigh);
        finished_d = (state_d == StFinish);
    end

    // State and output registers with asynchronous abort to reset values.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= StIdle;
            opcode_q   <= '0;
            pc_q       <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            wl_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            wl_seen_q  <= wl_seen_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            tmo_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            error_q   <= error_d;
        end
    end

    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    assign OpCode   = opcode_q;
    assign Pc       = pc_q;
    assign Busy     = busy_q;
    assign Finished = finished_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: a bench-side executor model drives Done,
// expected opcodes are queued when a run is started and popped as each instruction issues.

module tb_instruction_sequencer;

    localparam int OP_W = 20;
    localparam int A_W  = 6;

    logic            Clock;
    logic            ResetN;
    logic            LoadEn;
    logic [A_W-1:0]  LoadAddr;
    logic [OP_W-1:0] LoadData;
    logic [A_W:0]    Count;
    logic            Start;
    logic            Done;
    logic [OP_W-1:0] OpCode;
    logic [A_W:0]    Pc;
    logic            Busy;
    logic            Finished;
    logic            Error;

    instruction_sequencer #(
        .OP_W    (OP_W),
        .A_W     (A_W),
        .TIMEOUT (10)
    ) u_dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .LoadEn   (LoadEn),
        .LoadAddr (LoadAddr),
        .LoadData (LoadData),
        .Count    (Count),
        .Start    (Start),
        .Done     (Done),
        .OpCode   (OpCode),
        .Pc       (Pc),
        .Busy     (Busy),
        .Finished (Finished),
        .Error    (Error)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [OP_W-1:0] exp_q [$];
    logic [OP_W-1:0] model [2**A_W];

    // 0: handshake executor, 1: Done held high, 2: Done driven by the main thread
    int              exec_mode = 0;
    bit              capture   = 1'b0;
    int              hold      = 0;
    logic            busy_prev = 1'b0;
    logic [A_W:0]    pc_prev   = '0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor + executor model: a busy cycle with a new Pc is ISSUE; OpCode is valid one cycle on.
    initial begin
        logic [OP_W-1:0] e;
        forever begin
            @(negedge Clock);
            if (capture) begin
                capture = 1'b0;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_issue", 32'(OpCode), 32'hdead_beef);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("opcode", 32'(OpCode), 32'(e));
                end
                if (exec_mode == 0) begin
                    Done = 1'b0;
                    hold = 4;
                end
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) Done = 1'b1;
            end
            if (Busy && (!busy_prev || Pc != pc_prev)) capture = 1'b1;
            busy_prev = Busy;
            pc_prev   = Pc;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic load_word(input int addr, input logic [OP_W-1:0] data, input bit accepted);
        @(negedge Clock);
        LoadEn   = 1'b1;
        LoadAddr = addr[A_W-1:0];
        LoadData = data;
        if (accepted) model[addr] = data;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    task automatic start_run(input int cnt);
        @(negedge Clock);
        Count = cnt[A_W:0];
        Start = 1'b1;
        for (int i = 0; i < cnt; i++) exp_q.push_back(model[i]);
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int n = 0;
        while (!Finished && n < budget) begin
            @(negedge Clock);
            n++;
        end
        check_eq("finish_reached", 32'(Finished), 32'd1);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        ResetN   = 1'b1;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = '0;
        Count    = '0;
        Start    = 1'b0;
        Done     = 1'b1;
        #1 ResetN = 1'b0;
        repeat (2) @(negedge Clock);
        check_eq("rst_opcode", 32'(OpCode), 32'd0);
        check_eq("rst_pc", 32'(Pc), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_finished", 32'(Finished), 32'd0);
        check_eq("rst_error", 32'(Error), 32'd0);
        ResetN = 1'b1;

        load_word(0, 20'h00001, 1'b1);
        load_word(1, 20'h00002, 1'b1);
        load_word(2, 20'h00003, 1'b1);
        load_word(3, 20'h00004, 1'b1);

        // Three-instruction run with a handshaking executor, plus first-opcode latency.
        start_run(3);
        check_eq("latency_issue_edge", 32'(OpCode), 32'd0);
        @(negedge Clock);
        check_eq("latency_valid_edge", 32'(OpCode), 32'h00001);
        wait_finish(200);
        check_eq("run3_pc", 32'(Pc), 32'd3);
        check_eq("run3_opcode", 32'(OpCode), 32'd0);
        check_eq("run3_busy", 32'(Busy), 32'd0);

        // Count of zero: straight to FINISH, never busy.
        start_run(0);
        for (int i = 0; i < 4; i++) begin
            check_eq("cnt0_busy", 32'(Busy), 32'd0);
            @(negedge Clock);
        end
        check_eq("cnt0_finished", 32'(Finished), 32'd1);
        check_eq("cnt0_pc", 32'(Pc), 32'd0);
        check_eq("cnt0_opcode", 32'(OpCode), 32'd0);

        // A store write while busy is dropped; the re-run shows the original word.
        start_run(3);
        load_word(1, 20'hFFFFF, 1'b0);
        wait_finish(200);
        start_run(3);
        wait_finish(200);

        // Simultaneous load and start: the run reads the freshly written word 0.
        @(negedge Clock);
        LoadEn   = 1'b1;
        LoadAddr = '0;
        LoadData = 20'h0ABCD;
        model[0] = 20'h0ABCD;
        Count    = 7'd1;
        Start    = 1'b1;
        exp_q.push_back(model[0]);
        @(negedge Clock);
        LoadEn = 1'b0;
        Start  = 1'b0;
        wait_finish(200);
        check_eq("ldst_pc", 32'(Pc), 32'd1);

        // Asynchronous reset while in WAIT_HIGH at Pc=2, then restart with the store intact.
        start_run(3);
        for (int n = 0; n < 200 && !(Pc == 7'd2 && Busy); n++) @(negedge Clock);
        repeat (2) @(negedge Clock);
        check_eq("pre_rst_pc", 32'(Pc), 32'd2);
        check_eq("pre_rst_busy", 32'(Busy), 32'd1);
        #2 ResetN = 1'b0;
        #1;
        check_eq("abort_opcode", 32'(OpCode), 32'd0);
        check_eq("abort_pc", 32'(Pc), 32'd0);
        check_eq("abort_busy", 32'(Busy), 32'd0);
        check_eq("abort_finished", 32'(Finished), 32'd0);
        exp_q.delete();
        @(negedge Clock);
        ResetN = 1'b1;
        repeat (6) @(negedge Clock);
        start_run(3);
        wait_finish(200);
        check_eq("restart_pc", 32'(Pc), 32'd3);

        // Done held high: every instruction takes the single-cycle completion path.
        exec_mode = 1;
        start_run(4);
        wait_finish(200);
        check_eq("hold_pc", 32'(Pc), 32'd4);

        // Full store run: Pc reaches 2**A_W.
        for (int i = 0; i < 2**A_W; i++) load_word(i, OP_W'(i * 4099 + 17), 1'b1);
        start_run(2**A_W);
        wait_finish(1000);
        check_eq("full_pc", 32'(Pc), 32'(2**A_W));
        check_eq("full_opcode", 32'(OpCode), 32'd0);

`ifdef SEQ_TIMEOUT_EN
        // Done stuck low: the wait times out into FINISH with Error set.
        exec_mode = 2;
        @(negedge Clock);
        Done = 1'b0;
        start_run(1);
        for (int n = 0; n < 100 && !Error; n++) @(negedge Clock);
        check_eq("tmo_error", 32'(Error), 32'd1);
        check_eq("tmo_finished", 32'(Finished), 32'd1);
        check_eq("tmo_opcode", 32'(OpCode), 32'd0);
        check_eq("tmo_queue", 32'(exp_q.size()), 32'd0);
        Done      = 1'b1;
        exec_mode = 0;
        start_run(1);
        check_eq("tmo_error_clr", 32'(Error), 32'd0);
        wait_finish(200);
`else
        check_eq("error_tied_low", 32'(Error), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program-issue engine that sits in front of the `Excutor` and drives its `OpCode` input from an internal instruction store. It handshakes on the executor's `Done` level and advances a program counter after each completed instruction. It replaces a bench-side instruction feeder, so the executor can run a preloaded program stand-alone.

## Interface
- `OP_W`, 20, opcode width; matches the `Excutor` `OpCode` port.
- `A_W`, 6, program-store address width; depth is 2**A_W.
- `TIMEOUT`, 255, maximum cycles to wait in any handshake state (used only with the macro).

- `Clock`  in  1  single clock; all state updates on the rising edge.
- `ResetN`  in  1  asynchronous, active-low reset.
- `LoadEn`  in  1  write `LoadData` into the store at `LoadAddr`; honoured only in IDLE or FINISH.
- `LoadAddr`  in  A_W  store write address.
- `LoadData`  in  OP_W  instruction word to store.
- `Count`  in  A_W+1  number of instructions to run, 0..2**A_W; sampled on `Start`.
- `Start`  in  1  one-cycle pulse that begins a run from address 0; honoured only in IDLE or FINISH.
- `Done`  in  1  executor ready/complete level.
- `OpCode`  out  OP_W  instruction presented to the executor.
- `Pc`  out  A_W+1  index of the current instruction.
- `Busy`  out  1  high in ISSUE, WAIT_LOW and WAIT_HIGH.
- `Finished`  out  1  high in FINISH.
- `Error`  out  1  sticky timeout flag; stays 0 without the macro.

## Operation
- States: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, FINISH.
- IDLE or FINISH with `Start`=1:
  - Latch `Count` and set `Pc`=0.
  - If `Count`=0, go to FINISH; otherwise go to ISSUE.
- ISSUE:
  - Register `OpCode` = store[`Pc`].
  - Go to WAIT_LOW.
- WAIT_LOW:
  - Wait for `Done`=0, meaning the executor has taken the instruction, then go to WAIT_HIGH.
  - If `Done` is still 1 after 2 cycles in WAIT_LOW, treat the instruction as single-cycle complete and go directly to the WAIT_HIGH completion action.
- WAIT_HIGH, on `Done`=1:
  - `Pc` = `Pc`+1.
  - If the new `Pc` equals the latched count, go to FINISH; otherwise go to ISSUE.
- `OpCode` behaviour:
  - Held stable from ISSUE through WAIT_HIGH.
  - Forced to 0 in IDLE and FINISH.
- FINISH is held until the next `Start`.
- Simultaneous `LoadEn` and `Start` in the same cycle: the write completes, and the run reads the new word if `LoadAddr`=0.
- `LoadEn` while `Busy` is ignored. `Start` while `Busy` is ignored.
- The program store is not cleared by reset.

## Timing
- Reset values: `OpCode`=0, `Pc`=0, `Busy`=0, `Finished`=0, `Error`=0; state is IDLE.
- Reset mid-run aborts immediately, asynchronously, to these values.
- `Start` to first `OpCode` valid: 2 edges (IDLE→ISSUE, then the ISSUE edge registers `OpCode`).
- Instruction-to-instruction overhead: 1 cycle (ISSUE) after `Done` is sampled high.
- `Pc` updates on the same edge that samples `Done`=1 in WAIT_HIGH.
- `Count`=2**A_W runs the whole store; `Pc` reaches 2**A_W and is never used as an address.
- `Done` is a synchronous input; no internal synchroniser.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - An 8+-bit counter, cleared on every state change, counts cycles spent in WAIT_LOW or WAIT_HIGH.
  - Reaching `TIMEOUT` sets `Error`=1, forces `OpCode`=0 and enters FINISH.
  - `Error` clears on the next accepted `Start` or on reset.
- `SEQ_TIMEOUT_EN` undefined:
  - No counter; waits are unbounded.
  - `Error` is tied to 0.

## Test plan
- Load 3 words (0x00001, 0x00002, 0x00003), `Start` with `Count`=3, executor model drops `Done` 1 cycle and raises it 4 cycles later -> `OpCode` sequence 1, 2, 3; `Pc` ends at 3; `Finished`=1; `OpCode`=0.
- `Start` with `Count`=0 -> FINISH on the next edge; `OpCode` stays 0; `Busy` never asserts.
- `LoadEn` to address 1 with 0xFFFFF during a run -> store unchanged; a re-run shows the original word.
- Assert `ResetN`=0 while in WAIT_HIGH at `Pc`=2 -> all outputs at reset values immediately; a subsequent `Start` restarts at `Pc`=0 with the stored program intact.
- `Done` held at 1 throughout, `Count`=4 -> the single-cycle path is taken; all 4 opcodes issue; FINISH is reached.
- With `SEQ_TIMEOUT_EN`, `TIMEOUT`=10, `Done` stuck at 0 -> `Error`=1 after 10 wait cycles, state FINISH, `OpCode`=0; next `Start` clears `Error`.
